// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector: runtime pattern/length, overlap mode,
// input-valid qualifier and a saturating match counter.
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  input  logic             x,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err,
  output logic             armed
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int CW     = ((LEN_W > FILL_W) ? LEN_W : FILL_W) + 1;

  localparam logic [1:0] UNCFG = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] ERR   = 2'd2;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  logic [1:0]        state;
  logic [PAT_W-1:0]  pat_q, hist, cand, mask;
  logic [LEN_W-1:0]  len_q;
  logic              ovl_q;
  logic [FILL_W-1:0] fill;
  logic              cfg_ok, filled, hit, sample;

  assign cfg_ok = (cfg_len != '0) && (CW'(cfg_len) <= CW'(PAT_W));
  assign cand   = {hist[PAT_W-2:0], x};

  // Bits at or above the programmed length are don't-care in the compare.
  for (genvar i = 0; i < PAT_W; i++) begin : g_mask
    assign mask[i] = (CW'(len_q) > CW'(i));
  end

  assign filled = (CW'(fill) + CW'(1)) >= CW'(len_q);
  assign hit    = ((cand ^ pat_q) & mask) == '0;
  assign sample = (state == RUN) & in_valid & ~cfg_load;
  assign match  = armed & sample & filled & hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNCFG;
      armed   <= 1'b0;
      cfg_err <= 1'b0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist    <= '0;
      fill    <= '0;
    end else if (cfg_load) begin
      if (cfg_ok) begin
        state   <= RUN;
        armed   <= 1'b1;
        cfg_err <= 1'b0;
        pat_q   <= cfg_pattern;
        len_q   <= cfg_len;
        ovl_q   <= cfg_overlap;
        hist    <= '0;
        fill    <= '0;
      end else begin
        // Shadow config is kept; the block stays parked until a legal load.
        state   <= ERR;
        armed   <= 1'b0;
        cfg_err <= 1'b1;
      end
    end else if (sample) begin
      if (match && !ovl_q) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= cand;
        fill <= (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           match_cnt <= '0;
    else if (cnt_clr)                     match_cnt <= '0;
    else if (match && match_cnt != CNT_MAX) match_cnt <= match_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; a second instance with CNT_W=2
// shares the inputs to exercise counter saturation.
module tb_seq_detector_param;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cfg_load = 1'b0, cfg_overlap = 1'b0, in_valid = 1'b0, x = 1'b0, cnt_clr = 1'b0;
  logic [7:0]  cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic        match, cfg_err, armed;
  logic [15:0] match_cnt;
  logic        match2, cfg_err2, armed2;
  logic [1:0]  cnt2;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
    .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt), .cfg_err(cfg_err),
    .armed(armed));

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
    .cnt_clr(cnt_clr), .match(match2), .match_cnt(cnt2), .cfg_err(cfg_err2),
    .armed(armed2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic bit_in(input string tag, input logic v, input logic b, input logic em);
    in_valid = v; x = b;
    #1 chk(tag, 32'(match), 32'(em));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // bits/exp are MSB-first over the low n positions
  task automatic stream(input string tag, input logic [7:0] bits, input int n, input logic [7:0] exp);
    for (int i = n - 1; i >= 0; i--)
      bit_in($sformatf("%s[%0d]", tag, n - 1 - i), 1'b1, bits[i], exp[i]);
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    repeat (2) @(negedge clk);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    chk("rst_cnt2", 32'(cnt2), 0);
    in_valid = 1'b1; x = 1'b1;
    #1 chk("rst_match", 32'(match), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    bit_in("uncfg", 1'b1, 1'b1, 1'b0);

    // overlapping 101
    load(8'b0000_0101, 4'd3, 1'b1);
    chk("t1_armed", 32'(armed), 1);
    chk("t1_err", 32'(cfg_err), 0);
    stream("t1", 8'b0001_0101, 6, 8'b0000_0101);
    chk("t1_cnt", 32'(match_cnt), 2);

    // non-overlapping 101
    clr_cnt();
    chk("t2_clr", 32'(match_cnt), 0);
    load(8'b0000_0101, 4'd3, 1'b0);
    stream("t2", 8'b0001_0101, 6, 8'b0000_0100);
    chk("t2_cnt", 32'(match_cnt), 1);

    // in_valid gap inside a partial match
    clr_cnt();
    load(8'b0000_0101, 4'd3, 1'b1);
    bit_in("t3_b0", 1'b1, 1'b1, 1'b0);
    bit_in("t3_b1", 1'b1, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) bit_in($sformatf("t3_gap%0d", g), 1'b0, 1'b1, 1'b0);
    bit_in("t3_b2", 1'b1, 1'b1, 1'b1);
    chk("t3_cnt", 32'(match_cnt), 1);

    // illegal lengths, then full-width pattern
    load(8'hFF, 4'd0, 1'b1);
    chk("t4_err0", 32'(cfg_err), 1);
    chk("t4_armed0", 32'(armed), 0);
    stream("t4_err", 8'b0000_0101, 3, 8'h00);
    load(8'hA5, 4'd9, 1'b1);
    chk("t4_err9", 32'(cfg_err), 1);
    load(8'hA5, 4'd8, 1'b1);
    chk("t4_err_clr", 32'(cfg_err), 0);
    chk("t4_armed", 32'(armed), 1);
    stream("t4_a5", 8'hA5, 8, 8'h01);
    chk("t4_cnt", 32'(match_cnt), 2);

    // cfg_load wins over a same-cycle sample
    cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b0;
    cfg_load = 1'b1; in_valid = 1'b1; x = 1'b1;
    #1 chk("sim_match", 32'(match), 0);
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b0;
    chk("sim_cnt", 32'(match_cnt), 2);

    // len=1 every cycle, 2-bit counter saturation, clear beats match
    clr_cnt();
    for (int k = 0; k < 5; k++) begin
      bit_in($sformatf("t5_m%0d", k), 1'b1, 1'b1, 1'b1);
      chk($sformatf("t5_cnt2_%0d", k), 32'(cnt2), 32'(sat_exp[k]));
    end
    chk("t5_cnt", 32'(match_cnt), 5);
    cnt_clr = 1'b1;
    bit_in("t5_clr_m", 1'b1, 1'b1, 1'b1);
    cnt_clr = 1'b0;
    chk("t5_clr_cnt2", 32'(cnt2), 0);
    chk("t5_clr_cnt", 32'(match_cnt), 0);

    // asynchronous reset mid-pattern
    load(8'b0000_0101, 4'd3, 1'b1);
    stream("t6_pre", 8'b0000_0101, 3, 8'b0000_0001);
    chk("t6_pre_cnt", 32'(match_cnt), 1);
    bit_in("t6_b0", 1'b1, 1'b1, 1'b0);
    bit_in("t6_b1", 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("t6_armed", 32'(armed), 0);
    chk("t6_cnt", 32'(match_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stream("t6_post", 8'b0000_0101, 3, 8'h00);
    chk("t6_post_armed", 32'(armed), 0);
    chk("t6_post_cnt", 32'(match_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
